// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide controller and its datapath.
package md_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } md_result_t;

  function automatic logic is_mul_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_core.sv
// Combinational 64-bit HI/LO result for mult/multu/div/divu, plus divide-by-zero flag.
module mult_div_core
  import md_pkg::*;
(
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output md_result_t      result_c,
  output logic            div_by_zero_c
);

  logic              sgn_mul;
  logic              sgn_div;
  logic [2*XLEN-1:0] ext_a;
  logic [2*XLEN-1:0] ext_b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   q_mag;
  logic [XLEN-1:0]   r_mag;

  // Single shared multiplier; signedness handled by operand extension.
  // Divide works on magnitudes so 0x80000000 / -1 falls out without overflow.
  always_comb begin
    result_c      = '0;
    div_by_zero_c = (b == '0);
    sgn_mul       = (op == MD_MULT);
    sgn_div       = (op == MD_DIV);
    ext_a         = {{XLEN{sgn_mul & a[XLEN-1]}}, a};
    ext_b         = {{XLEN{sgn_mul & b[XLEN-1]}}, b};
    prod          = ext_a * ext_b;
    a_mag         = (sgn_div && a[XLEN-1]) ? XLEN'(-a) : a;
    b_mag         = (sgn_div && b[XLEN-1]) ? XLEN'(-b) : b;
    q_mag         = (b_mag == '0) ? '0 : a_mag / b_mag;
    r_mag         = (b_mag == '0) ? '0 : a_mag % b_mag;

    case (op)
      MD_MULT, MD_MULTU: result_c = md_result_t'(prod);
      MD_DIV: begin
        result_c.lo = (a[XLEN-1] ^ b[XLEN-1]) ? XLEN'(-q_mag) : q_mag;
        result_c.hi = a[XLEN-1] ? XLEN'(-r_mag) : r_mag;
      end
      MD_DIVU: begin
        result_c.lo = q_mag;
        result_c.hi = r_mag;
      end
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models fixed latency and drives md_busy for hazard stalls.
module mult_div_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            md_start,
  input  md_op_e          md_op,
  input  logic [XLEN-1:0] md_a,
  input  logic [XLEN-1:0] md_b,
  input  logic            rd_hi,
  output logic [XLEN-1:0] md_rdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            md_busy
);

  localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e   state;
  logic [CNT_W-1:0] cnt;
  md_result_t  res_q;
  logic        wr_q;
  md_result_t  core_res;
  logic        core_dz;

  mult_div_core u_core (
    .op            (md_op),
    .a             (md_a),
    .b             (md_b),
    .result_c      (core_res),
    .div_by_zero_c (core_dz)
  );

  // Result is captured at issue; HI/LO only change when the latency window closes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      md_busy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (md_start) begin
            case (md_op)
              MD_MULT, MD_MULTU: begin
                res_q   <= core_res;
                wr_q    <= 1'b1;
                cnt     <= CNT_W'(MULT_CYCLES - 1);
                state   <= ST_BUSY;
                md_busy <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                res_q   <= core_res;
                wr_q    <= ~core_dz;
                cnt     <= CNT_W'(DIV_CYCLES - 1);
                state   <= ST_BUSY;
                md_busy <= 1'b1;
              end
              MD_MTHI: hi <= md_a;
              MD_MTLO: lo <= md_a;
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            state   <= ST_IDLE;
            md_busy <= 1'b0;
            if (wr_q) begin
              hi <= res_q.hi;
              lo <= res_q.lo;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          md_busy <= 1'b0;
        end
      endcase
    end
  end

  // Architectural read port for mfhi/mflo; pre-op values while busy.
  assign md_rdata = rd_hi ? hi : lo;

  // The hazard controller must stall any MD issue while an operation is in flight.
  always_ff @(posedge clk) begin
    if (!reset && state == ST_BUSY) begin
      assert (!md_start)
      else $warning("mult_div_ctrl: md_start while busy ignored (op %0d)", md_op);
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed and randomized checks of mult_div_ctrl against an arithmetic reference model.
module tb_mult_div_ctrl;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_start;
  md_op_e      md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        rd_hi;
  logic [31:0] md_rdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        md_busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mult_div_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .md_start (md_start),
    .md_op    (md_op),
    .md_a     (md_a),
    .md_b     (md_b),
    .rd_hi    (rd_hi),
    .md_rdata (md_rdata),
    .hi       (hi),
    .lo       (lo),
    .md_busy  (md_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the specified semantics.
  function automatic logic [63:0] ref_md(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] h, input logic [31:0] l);
    int          sa;
    int          sb;
    longint      sp;
    longint      sq;
    longint      sr;
    longint unsigned up;
    logic [63:0] r;
    sa = a;
    sb = b;
    r  = {h, l};
    case (op)
      MD_MULT: begin sp = longint'(sa) * longint'(sb); r = sp; end
      MD_MULTU: begin up = longint'({32'b0, a}) * longint'({32'b0, b}); r = up; end
      MD_DIV: if (b != 0) begin
        sq = longint'(sa) / longint'(sb);
        sr = longint'(sa) % longint'(sb);
        r = {sr[31:0], sq[31:0]};
      end
      MD_DIVU: if (b != 0) r = {a % b, a / b};
      MD_MTHI: r = {a, l};
      MD_MTLO: r = {h, a};
      default: r = {h, l};
    endcase
    return r;
  endfunction

  function automatic int latency(input md_op_e op);
    if (op == MD_MULT || op == MD_MULTU) return 5;
    if (op == MD_DIV || op == MD_DIVU) return 10;
    return 0;
  endfunction

  task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_start = 1'b1;
    md_op    = op;
    md_a     = a;
    md_b     = b;
    @(posedge clk);
    #1;
    md_start = 1'b0;
    md_op    = MD_NONE;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    rd_hi = 1'b1;
    #1 check({tag, "_rd_hi"}, md_rdata, exp_hi);
    rd_hi = 1'b0;
    #1 check({tag, "_rd_lo"}, md_rdata, exp_lo);
  endtask

  // Issues one op, checks busy window, pre-op reads and the final HI/LO.
  task automatic do_op(input string tag, input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    int n;
    n = latency(op);
    r = ref_md(op, a, b, exp_hi, exp_lo);
    issue(op, a, b);
    for (int k = 1; k <= n; k++) begin
      check({tag, "_busy"}, 32'(md_busy), 32'd1);
      check({tag, "_rd_pre"}, md_rdata, rd_hi ? exp_hi : exp_lo);
      @(posedge clk);
      #1;
    end
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    check({tag, "_idle"}, 32'(md_busy), 32'd0);
    check_regs(tag);
  endtask

  initial begin
    md_op_e rop;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1; md_start = 1'b0; md_op = MD_NONE; md_a = '0; md_b = '0; rd_hi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_regs("reset");
    check("reset_busy", 32'(md_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset during an in-flight multiply discards it.
    issue(MD_MULT, 32'd3, 32'd4);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_busy", 32'(md_busy), 32'd0);
    check_regs("rst_mid");
    repeat (8) @(posedge clk);
    #1;
    check("rst_mid_late_busy", 32'(md_busy), 32'd0);
    check_regs("rst_mid_late");

    do_op("mult_sgn", MD_MULT, 32'hFFFF_FFFF, 32'd2);
    check("mult_sgn_hi_abs", hi, 32'hFFFF_FFFF);
    check("mult_sgn_lo_abs", lo, 32'hFFFF_FFFE);
    do_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    check("multu_hi_abs", hi, 32'h0000_0001);
    do_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_lo_abs", lo, 32'hFFFF_FFFD);
    check("div_neg_hi_abs", hi, 32'hFFFF_FFFF);
    do_op("divu", MD_DIVU, 32'd7, 32'd2);
    check("divu_lo_abs", lo, 32'd3);
    do_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo_abs", lo, 32'h8000_0000);
    check("div_ovf_hi_abs", hi, 32'h0);

    do_op("mthi_pre", MD_MTHI, 32'h11, 32'd0);
    do_op("mtlo_pre", MD_MTLO, 32'h22, 32'd0);
    do_op("divu_zero", MD_DIVU, 32'd7, 32'd0);
    check("divz_hi_abs", hi, 32'h11);
    check("divz_lo_abs", lo, 32'h22);

    // MTHI then MTLO back-to-back, each visible the next cycle.
    issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
    check("mthi_busy", 32'(md_busy), 32'd0);
    rd_hi = 1'b1;
    #1 check("mthi_rd", md_rdata, 32'hDEAD_BEEF);
    issue(MD_MTLO, 32'h1234, 32'd0);
    check("mtlo_busy", 32'(md_busy), 32'd0);
    rd_hi = 1'b0;
    #1 check("mtlo_rd", md_rdata, 32'h1234);
    rd_hi = 1'b1;
    #1 check("mtlo_rd_hi", md_rdata, 32'hDEAD_BEEF);
    rd_hi = 1'b0;
    exp_hi = 32'hDEAD_BEEF;
    exp_lo = 32'h1234;

    // Start while busy is ignored; the cycle busy drops accepts a new op.
    issue(MD_MULT, 32'd2, 32'd3);
    check("b2b_busy1", 32'(md_busy), 32'd1);
    @(negedge clk);
    md_start = 1'b1; md_op = MD_MULT; md_a = 32'd5; md_b = 32'd5;
    @(posedge clk); #1;
    md_start = 1'b0; md_op = MD_NONE;
    for (int k = 2; k <= 5; k++) begin
      check("b2b_busy", 32'(md_busy), 32'd1);
      @(posedge clk); #1;
    end
    exp_hi = 32'd0;
    exp_lo = 32'd6;
    check("b2b_idle", 32'(md_busy), 32'd0);
    check_regs("b2b_first");
    do_op("b2b_second", MD_MULT, 32'd5, 32'd5);
    check("b2b_second_lo_abs", lo, 32'd25);

    // Randomized ops against the reference model.
    for (int i = 0; i < 24; i++) begin
      rop = md_op_e'(4'($urandom_range(0, 6)));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      rd_hi = 1'($urandom_range(0, 1));
      do_op("rand", rop, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
- Sequences the pipeline's multiply/divide resource: accepts MD ops issued from EX, holds architectural HI/LO, models fixed multi-cycle latency.
- Drives the busy/start indication the hazard controller uses to stall ID-stage MD instructions.
- Sits beside the ALU in EX. HI/LO reads serve mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- md_start  input  1  EX-stage valid MD op this cycle; also exported as the hazard start indication.
- md_op  input  4  op code (package enum).
- md_a  input  32  operand rs (forwarded).
- md_b  input  32  operand rt (forwarded).
- rd_hi  input  1  1 = read HI, 0 = read LO.
- md_rdata  output  32  combinational HI or LO per rd_hi, from architectural registers.
- hi  output  32  HI register.
- lo  output  32  LO register.
- md_busy  output  1  operation in flight.

Behaviour:
- Clock/reset: single clock clk; reset is synchronous, active-high. When reset is sampled high:
  - hi=0, lo=0, md_busy=0, state IDLE, counter=0.
  - Any in-flight op is discarded; HI/LO not updated by it.
- States: IDLE, BUSY.
- IDLE + md_start + op in {MULT,MULTU,DIV,DIVU} at cycle T:
  - Latch 64-bit result and op class; counter <= N-1; go BUSY.
  - N = MULT_CYCLES or DIV_CYCLES.
  - md_busy high in cycles T+1..T+N.
  - At the edge ending T+N: HI/LO written, state -> IDLE. New values visible from cycle T+N+1.
- IDLE + md_start + MTHI/MTLO: hi (or lo) <= md_a at the edge; visible next cycle; md_busy stays 0.
- MD_NONE or md_start=0: no action.
- md_start while BUSY: ignored; simulation assertion fires. The hazard controller guarantees this never occurs.
- Counter: decrements each BUSY cycle. At 0, complete and return to IDLE. No wrap.
- mult: signed 32x32 -> 64. HI = bits[63:32], LO = bits[31:0].
- multu: unsigned 32x32 -> 64, same HI/LO split.
- div: LO = quotient truncated toward zero; HI = remainder with sign of dividend.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- divu: unsigned quotient/remainder.
- Divide by zero (md_b=0): full DIV_CYCLES busy; HI/LO unchanged at completion.
- Reads: md_rdata always reflects current registers. During BUSY it returns pre-op values; ID stalls mfhi/mflo via md_busy anyway.
- Cycle T+N+1 (busy drops): a new md_start is accepted in that same cycle.

Decomposition:
- Shared package md_pkg:
  - md_op enum: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
  - State enum (IDLE/BUSY).
  - Default latency constants.
- One sub-module, mult_div_core: combinational 64-bit result generation incl. div-by-zero flag. The controller owns state, counter and HI/LO.

Test Plan:
- Reset mid-operation: start MULT 3*4, assert reset at cycle T+2 -> hi=0, lo=0, md_busy=0 next cycle; no later update.
- Signed vs unsigned multiply: md_a=0xFFFFFFFF, md_b=2:
  - MULT -> busy cycles T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - MULTU -> hi=0x00000001, lo=0xFFFFFFFE.
- Signed divide: DIV -7/2 -> busy exactly 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/2 -> lo=3, hi=1.
- Edge cases:
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU 7/0 with hi=0x11, lo=0x22 preset -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- MTHI/MTLO: MTHI 0xDEADBEEF then MTLO 0x1234 back-to-back -> md_busy never high; rd_hi=1 gives 0xDEADBEEF, rd_hi=0 gives 0x1234, each one cycle after its write.
- Back-to-back ops: MULT 2*3 with md_start re-asserted (MULT 5*5) during busy -> second ignored and assertion flagged; lo=6. Then a MULT 5*5 issued in the first cycle busy is low is accepted -> lo=25.
